// File: rtl/mem_model_pkg.sv
// Shared definitions for the avalon_wait_ram memory model.
//   state_t        : controller states (IDLE, WAIT, CLEAR)
//   LFSR_TAPS      : tap mask for x^8+x^6+x^5+x^4+1 (Fibonacci form, shift left)
//   FAULT_*        : bit positions of the individual bus-fault causes
//   lfsr_next()    : one LFSR step
package mem_model_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Taps on stages 8, 6, 5, 4 -> register bits 7, 5, 4, 3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int FAULT_RW_BOTH  = 0;  // read and write asserted together
    localparam int FAULT_MISALIGN = 1;  // address[1:0] nonzero
    localparam int FAULT_RANGE    = 2;  // address outside the mapped window
    localparam int FAULT_COUNT    = 3;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr8_stall.sv
// Pseudo-random stall generator: 8-bit maximal-length LFSR plus the
// modulo reduction to a stall count in 0..WAIT_CYCLES.
//   clk    in  clock
//   reset  in  synchronous active-high reset, loads SEED
//   stall  out current stall count (lfsr % (WAIT_CYCLES+1))
module lfsr8_stall
    import mem_model_pkg::*;
#(
    parameter logic [7:0] SEED        = 8'hA5,
    parameter int         WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] stall
);

    // Nine bits so WAIT_CYCLES = 255 gives a modulus of 256.
    localparam logic [8:0] MODULUS = 9'(WAIT_CYCLES + 1);

    logic [7:0] lfsr;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) lfsr <= SEED;
        else       lfsr <= lfsr_next(lfsr);
    end

    assign stall = 8'({1'b0, lfsr} % MODULUS);

endmodule

// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave memory with programmable waitrequest stalls, a clocked
// preload port, a one-word-per-cycle clear sweep and a sticky bus-error flag.
//   clk, reset          : clock, synchronous active-high reset
//   address/read/write  : Avalon byte address and request strobes
//   writedata/byteenable: write data with per-byte enables
//   waitrequest         : stall; transfer completes when request high and this low
//   readdata            : read word during the accept cycle of a read, else 0
//   load_en/addr/data   : full-word preload, one word per edge
//   clear / busy        : start / progress of the zeroing sweep
//   bus_error           : sticky flag for protocol and address faults
module avalon_wait_ram
    import mem_model_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 2,
    parameter int          STALL_MODE  = 0,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             address,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    input  logic                    load_en,
    input  logic [ADDR_WIDTH-1:0]   load_addr,
    input  logic [DATA_WIDTH-1:0]   load_data,
    input  logic                    clear,
    output logic                    busy,
    output logic                    bus_error
);

    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state, next_state;
    logic [7:0]            count, next_count;
    logic [ADDR_WIDTH-1:0] clr_idx, next_clr_idx;
    logic                  clear_pend, next_clear_pend;
    logic                  accept;
    logic                  req;
    logic [7:0]            stall_n;

    // Address decode: word index relative to BASE_ADDR, low two bits ignored.
    logic [31:0]            offset;
    logic                   in_range;
    logic [ADDR_WIDTH-1:0]  word_idx;
    logic [FAULT_COUNT-1:0] fault;

    assign req      = read | write;
    assign offset   = address - BASE_ADDR;
    assign in_range = (address >= BASE_ADDR) &&
                      ({32'd0, offset} < (64'd1 << (ADDR_WIDTH + 2)));
    assign word_idx = offset[ADDR_WIDTH+1:2];

    always_comb begin
        fault                 = '0;
        fault[FAULT_RW_BOTH]  = read & write;
        fault[FAULT_MISALIGN] = (address[1:0] != 2'b00);
        fault[FAULT_RANGE]    = !in_range;
    end

    generate
        if (STALL_MODE == 1) begin : g_random
            lfsr8_stall #(
                .SEED        (SEED),
                .WAIT_CYCLES (WAIT_CYCLES)
            ) u_stall (
                .clk   (clk),
                .reset (reset),
                .stall (stall_n)
            );
        end else begin : g_fixed
            assign stall_n = 8'(WAIT_CYCLES);
        end
    endgenerate

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        next_state      = state;
        next_count      = count;
        next_clr_idx    = clr_idx;
        next_clear_pend = clear_pend;
        waitrequest     = 1'b1;
        accept          = 1'b0;

        unique case (state)
            IDLE: begin
                if (clear || clear_pend) begin
                    next_state      = CLEAR;
                    next_clr_idx    = '0;
                    next_clear_pend = 1'b0;
                end else if (!load_en && req) begin
                    // A preload cycle stalls the bus and freezes the handshake.
                    if (stall_n == 8'd0) begin
                        waitrequest = 1'b0;
                        accept      = 1'b1;
                    end else begin
                        next_count = stall_n - 8'd1;
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                // A clear arriving mid-transfer is remembered until IDLE.
                if (clear) next_clear_pend = 1'b1;
                if (!load_en) begin
                    if (!req) begin
                        next_state = IDLE;
                    end else if (count != 8'd0) begin
                        next_count = count - 8'd1;
                    end else begin
                        waitrequest = 1'b0;
                        accept      = 1'b1;
                        next_state  = IDLE;
                    end
                end
            end
            CLEAR: begin
                if (&clr_idx) next_state   = IDLE;
                else          next_clr_idx = clr_idx + 1'b1;
            end
            default: next_state = IDLE;
        endcase

        if (reset) begin
            waitrequest = 1'b1;
            accept      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            clr_idx    <= '0;
            clear_pend <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            state      <= next_state;
            count      <= next_count;
            clr_idx    <= next_clr_idx;
            clear_pend <= next_clear_pend;
            if (accept && (|fault)) bus_error <= 1'b1;
        end
    end

    // NOTE: the array has no reset branch; it maps onto plain RAM and its
    // contents survive reset (a reset only stops writes in that cycle).
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (load_en) begin
                mem[load_addr] <= load_data;
            end else if (accept && write && in_range) begin
                for (int b = 0; b < BE_WIDTH; b++) begin
                    if (byteenable[b]) mem[word_idx][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    // Simultaneous read+write is handled as a write, so no read data then.
    assign readdata = (accept && read && !write && in_range) ? mem[word_idx] : '0;
    assign busy     = (state == CLEAR) && !reset;

endmodule
